// File: rtl/mii_pkg.sv
// Shared MII definitions: TX state encoding, wire nibbles and CRC-32 constants.
// Used by the framer and the byte-wide CRC-32 helper.
package mii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_UNDR,
        ST_IFG
    } tx_state_e;

    localparam logic [3:0]  MII_PREAMBLE    = 4'h5;
    localparam logic [3:0]  MII_SFD         = 4'hD;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

endpackage

// File: rtl/eth_crc32_d8.sv
// Reflected Ethernet CRC-32, one byte per call, LSB of the byte first.
// Pure combinational; shared by the TX framer and the RX FCS check.
module eth_crc32_d8
    import mii_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    // Eight serial shift/xor steps unrolled into one cycle.
    always_comb begin
        logic [31:0] c;
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_i[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
            else                  c = c >> 1;
        end
        crc_o = c;
    end

endmodule

// File: rtl/mii_tx_framer.sv
// MII transmit framer: preamble, SFD, client bytes, IFG; one nibble per clk.
// Define MII_TX_FCS_EN to add zero padding to MIN_FRAME_BYTES and a CRC-32 FCS.
module mii_tx_framer
    import mii_pkg::*;
#(
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int IFG_NIBBLES      = 24,
    parameter int MIN_FRAME_BYTES  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       mii_tx_en,
    output logic [3:0] mii_txd,
    output logic       mii_tx_er,
    output logic       busy
);

    localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_NIBBLES);
    localparam logic [4:0] IFG_LAST = 5'(IFG_NIBBLES);

    tx_state_e  state_q;
    logic [4:0] cnt_q;
    logic       phase_q;
    logic       last_q;
    logic [3:0] hi_q;
    logic       mii_tx_en_q;
    logic [3:0] mii_txd_q;
    logic       mii_tx_er_q;
    logic       start;

    // A byte is needed on the SFD nibble and on every high nibble but the last.
    assign tx_ready = (state_q == ST_SFD) ||
                      (state_q == ST_DATA && phase_q && !last_q);

    // A frame may start from IDLE or straight off the final IFG nibble.
    assign start = tx_valid &&
                   (state_q == ST_IDLE ||
                    (state_q == ST_IFG && cnt_q == IFG_LAST));

    assign busy      = (state_q != ST_IDLE);
    assign mii_tx_en = mii_tx_en_q;
    assign mii_txd   = mii_txd_q;
    assign mii_tx_er = mii_tx_er_q;

`ifdef MII_TX_FCS_EN
    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [10:0] bcnt_q;
    logic [10:0] bcnt_inc;
    logic [7:0]  crc_byte;
    logic        pad_more;

    // Pad bytes are loaded outside the tx_ready slots and are always zero.
    assign crc_byte = tx_ready ? tx_data : 8'h00;
    assign bcnt_inc = (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;
    assign pad_more = (bcnt_q < 11'(MIN_FRAME_BYTES));

    eth_crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (crc_byte),
        .crc_o  (crc_d)
    );
`endif

    // Frame FSM; the MII outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            last_q      <= 1'b0;
            hi_q        <= '0;
            mii_tx_en_q <= 1'b0;
            mii_txd_q   <= '0;
            mii_tx_er_q <= 1'b0;
`ifdef MII_TX_FCS_EN
            crc_q       <= CRC32_INIT;
            bcnt_q      <= '0;
`endif
        end else if (start) begin
            state_q     <= ST_PRE;
            cnt_q       <= 5'd1;
            mii_tx_en_q <= 1'b1;
            mii_txd_q   <= MII_PREAMBLE;
            mii_tx_er_q <= 1'b0;
`ifdef MII_TX_FCS_EN
            crc_q       <= CRC32_INIT;
            bcnt_q      <= '0;
`endif
        end else if (tx_ready) begin
            if (tx_valid) begin
                state_q   <= ST_DATA;
                phase_q   <= 1'b0;
                last_q    <= tx_last;
                hi_q      <= tx_data[7:4];
                mii_txd_q <= tx_data[3:0];
`ifdef MII_TX_FCS_EN
                crc_q     <= crc_d;
                bcnt_q    <= bcnt_inc;
`endif
            end else begin
                state_q     <= ST_UNDR;
                mii_txd_q   <= '0;
                mii_tx_er_q <= 1'b1;
            end
        end else begin
            case (state_q)
                ST_PRE: begin
                    if (cnt_q == PRE_LAST) begin
                        state_q   <= ST_SFD;
                        mii_txd_q <= MII_SFD;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_DATA, ST_PAD: begin
                    if (!phase_q) begin
                        phase_q   <= 1'b1;
                        mii_txd_q <= hi_q;
                    end
`ifdef MII_TX_FCS_EN
                    else if (pad_more) begin
                        state_q   <= ST_PAD;
                        phase_q   <= 1'b0;
                        hi_q      <= '0;
                        mii_txd_q <= '0;
                        crc_q     <= crc_d;
                        bcnt_q    <= bcnt_inc;
                    end else begin
                        state_q   <= ST_FCS;
                        cnt_q     <= 5'd1;
                        mii_txd_q <= ~crc_q[3:0];
                        crc_q     <= {4'h0, crc_q[31:4]};
                    end
`else
                    else begin
                        state_q     <= ST_IFG;
                        cnt_q       <= 5'd1;
                        mii_tx_en_q <= 1'b0;
                        mii_txd_q   <= '0;
                    end
`endif
                end
`ifdef MII_TX_FCS_EN
                ST_FCS: begin
                    if (cnt_q == 5'd8) begin
                        state_q     <= ST_IFG;
                        cnt_q       <= 5'd1;
                        mii_tx_en_q <= 1'b0;
                        mii_txd_q   <= '0;
                    end else begin
                        cnt_q     <= cnt_q + 5'd1;
                        mii_txd_q <= ~crc_q[3:0];
                        crc_q     <= {4'h0, crc_q[31:4]};
                    end
                end
`endif
                ST_UNDR: begin
                    state_q     <= ST_IFG;
                    cnt_q       <= 5'd1;
                    mii_tx_en_q <= 1'b0;
                    mii_txd_q   <= '0;
                    mii_tx_er_q <= 1'b0;
                end
                ST_IFG: begin
                    if (cnt_q == IFG_LAST) state_q <= ST_IDLE;
                    else                   cnt_q   <= cnt_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
